// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: program-ROM fetch sequencer with jump, halt/resume and sticky range fault.
// Define IFETCH_PERF_CNT_EN to add saturating fetch_cnt/stall_cnt outputs.
module instr_fetch_ctrl #(
   parameter int ROM_WIDTH    = 21,
   parameter int ADDR_WIDTH   = 16,
   parameter int ROM_DEPTH    = 16,
   parameter int RESET_VECTOR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [ROM_WIDTH-1:0]  rom_data,
   output logic [ROM_WIDTH-1:0]  instr,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  jmp_valid,
   input  logic [ADDR_WIDTH-1:0] jmp_addr,
   input  logic                  halt_req,
   output logic                  halted,
   output logic                  fault
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0]           fetch_cnt,
   output logic [31:0]           stall_cnt
`endif
);
   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_FAULT} state_t;
   state_t state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n, addr_n;
   logic [ROM_WIDTH-1:0] instr_n;
   logic valid_n, halted_n, fault_n, fire, can_load, out_of_range;
   assign rom_addr = pc;
   assign fire = instr_valid & instr_ready;
   assign can_load = ~instr_valid | fire;
   assign out_of_range = pc >= ADDR_WIDTH'(ROM_DEPTH);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= S_BOOT;
         pc <= ADDR_WIDTH'(RESET_VECTOR);
         instr <= '0;
         instr_addr <= '0;
         instr_valid <= 1'b0;
         halted <= 1'b0;
         fault <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         instr <= instr_n;
         instr_addr <= addr_n;
         instr_valid <= valid_n;
         halted <= halted_n;
         fault <= fault_n;
      end
   always_comb begin
      state_n = state;
      pc_n = pc;
      instr_n = instr;
      addr_n = instr_addr;
      valid_n = instr_valid;
      halted_n = halted;
      fault_n = fault;
      case (state)
         S_BOOT: state_n = S_RUN;
         S_RUN:
            if (jmp_valid) begin
               pc_n = jmp_addr;
               valid_n = 1'b0;
            end else if (halt_req) begin
               valid_n = fire ? 1'b0 : instr_valid;
               // Enter halt only once no live instruction remains in the output register.
               if (can_load) begin
                  state_n = S_HALT;
                  halted_n = 1'b1;
               end
            end else if (can_load && out_of_range) begin
               valid_n = 1'b0;
               fault_n = 1'b1;
               state_n = S_FAULT;
            end else if (can_load) begin
               instr_n = rom_data;
               addr_n = pc;
               valid_n = 1'b1;
               pc_n = pc + 1'b1;
            end
         S_HALT: begin
            pc_n = jmp_valid ? jmp_addr : pc;
            if (!halt_req) begin
               state_n = S_RUN;
               halted_n = 1'b0;
            end
         end
         default: ;
      endcase
   end
`ifdef IFETCH_PERF_CNT_EN
   logic fetch_inc, stall_inc;
   assign fetch_inc = (state == S_RUN) & ~jmp_valid & ~halt_req & can_load & ~out_of_range;
   assign stall_inc = (state == S_RUN) & instr_valid & ~instr_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         fetch_cnt <= fetch_cnt + 32'(fetch_inc & ~&fetch_cnt);
         stall_cnt <= stall_cnt + 32'(stall_inc & ~&stall_cnt);
      end
`endif
endmodule
